// File: rtl/adsr_env.sv
// adsr_env: parametrised ADSR envelope generator, one instance per voice.
// The level moves one step per (stage interval + 1) clocks. Gate rise always
// restarts ATTACK. Gate fall releases from any gated state.
// Optional HOLD stage between ATTACK and DECAY: define ADSR_HOLD_EN, which
// also adds the hold_int port.
module adsr_env #(
  parameter int OUT_W = 7,
  parameter int INT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic             retrig_zero,
  input  logic [INT_W-1:0] a_int,
  input  logic [INT_W-1:0] d_int,
  input  logic [INT_W-1:0] r_int,
`ifdef ADSR_HOLD_EN
  input  logic [INT_W-1:0] hold_int,
`endif
  input  logic [OUT_W-1:0] sus_lvl,
  output logic [OUT_W-1:0] level,
  output logic             running,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4,
    HOLD    = 3'd5
  } state_e;

  localparam logic [OUT_W-1:0] LVL_MAX  = '1;
  localparam logic [OUT_W-1:0] LVL_ZERO = '0;
  localparam logic [OUT_W-1:0] LVL_ONE  = OUT_W'(1);

`ifdef ADSR_HOLD_EN
  localparam state_e PEAK_NEXT = HOLD;
`else
  localparam state_e PEAK_NEXT = DECAY;
`endif

  state_e           state_q, state_d;
  logic [OUT_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] lvl_up, lvl_dn;
  logic [INT_W-1:0] cnt_q, cnt_d, cur_int;
  logic             gate_q;
  logic             done_q, done_d;
  logic             rise, fall, timed, tick;

  assign rise   = gate & ~gate_q;
  assign fall   = ~gate & gate_q;
  assign lvl_up = level_q + LVL_ONE;
  assign lvl_dn = level_q - LVL_ONE;

  // Pick the live interval of the current stage; IDLE and SUSTAIN are untimed.
  always_comb begin
    cur_int = '0;
    timed   = 1'b0;
    case (state_q)
      ATTACK:  begin cur_int = a_int;    timed = 1'b1; end
      DECAY:   begin cur_int = d_int;    timed = 1'b1; end
      RELEASE: begin cur_int = r_int;    timed = 1'b1; end
`ifdef ADSR_HOLD_EN
      HOLD:    begin cur_int = hold_int; timed = 1'b1; end
`endif
      default: ;
    endcase
  end

  // >= rather than ==: an interval cut below the running count ticks at once
  // instead of letting the counter run all the way around.
  assign tick = timed & (cnt_q >= cur_int);

  // Next state and level. Priority is rise, then fall, then the stage tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = ATTACK;
      if (retrig_zero) level_d = LVL_ZERO;
    end else if (fall && state_q != IDLE && state_q != RELEASE) begin
      state_d = RELEASE;
    end else begin
      case (state_q)
        ATTACK: if (tick) begin
          // A retrigger that starts at MAX just leaves on the first tick.
          if (level_q != LVL_MAX) level_d = lvl_up;
          if (level_q == LVL_MAX || lvl_up == LVL_MAX) state_d = PEAK_NEXT;
        end
        DECAY: if (tick) begin
          if (level_q == LVL_ZERO || lvl_dn <= sus_lvl) begin
            // Land exactly on the sustain level. A zero sustain ends the note.
            level_d = sus_lvl;
            state_d = (sus_lvl == LVL_ZERO) ? IDLE : SUSTAIN;
          end else begin
            level_d = lvl_dn;
          end
        end
        SUSTAIN: level_d = sus_lvl;
        RELEASE: if (tick) begin
          if (level_q <= LVL_ONE) begin
            level_d = LVL_ZERO;
            state_d = IDLE;
          end else begin
            level_d = lvl_dn;
          end
        end
`ifdef ADSR_HOLD_EN
        HOLD: if (tick) state_d = DECAY;
`endif
        default: ;
      endcase
    end
  end

  // Stage timer restarts on every stage change, on rise and on each step.
  always_comb begin
    if (rise || state_d != state_q || tick || !timed) cnt_d = '0;
    else                                              cnt_d = cnt_q + INT_W'(1);
    done_d = (state_d == IDLE) && (state_q != IDLE);
  end

  // State, level, timer, gate history and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate;
      done_q  <= done_d;
    end
  end

  assign level   = level_q;
  assign state   = state_q;
  assign running = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed envelope scenarios plus a long random gate/interval
// run. Both are compared every cycle against an integer envelope model.
module tb_adsr_env;
  localparam int OUT_W = 8;
  localparam int INT_W = 8;
  localparam int MAXL  = 255;
`ifdef ADSR_HOLD_EN
  localparam int POST = 5;   // stage after the attack peak
  localparam int HX   = 1;   // extra clocks spent in HOLD with hold_int=0
`else
  localparam int POST = 2;
  localparam int HX   = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, gate, retrig_zero;
  logic [INT_W-1:0] a_int, d_int, r_int;
`ifdef ADSR_HOLD_EN
  logic [INT_W-1:0] hold_int;
`endif
  logic [OUT_W-1:0] sus_lvl, level;
  logic running, done;
  logic [2:0] state;

  int total = 0, passed = 0;
  bit chk_en = 0;

  adsr_env #(.OUT_W(OUT_W), .INT_W(INT_W)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate), .retrig_zero(retrig_zero),
    .a_int(a_int), .d_int(d_int), .r_int(r_int),
`ifdef ADSR_HOLD_EN
    .hold_int(hold_int),
`endif
    .sus_lvl(sus_lvl), .level(level), .running(running), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (plain integers) ----------------
  // Phases: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release, 5 hold.
  // m_wait counts clocks spent waiting for the next level step of a phase.
  int m_lvl = 0, m_st = 0, m_wait = 0;
  bit m_done = 0, m_gprev = 0;

  function automatic int phase_interval(int ph);
    case (ph)
      1: return int'(a_int);
      2: return int'(d_int);
      4: return int'(r_int);
`ifdef ADSR_HOLD_EN
      5: return int'(hold_int);
`endif
      default: return -1;
    endcase
  endfunction

  task automatic model_clock();
    int  ival = phase_interval(m_st);
    bit  up   = gate && !m_gprev;
    bit  dn   = !gate && m_gprev;
    bit  step = (ival >= 0) && (m_wait >= ival);
    int  nph  = m_st;
    int  nl   = m_lvl;
    int  s    = int'(sus_lvl);
    if (up) begin
      nph = 1;
      if (retrig_zero) nl = 0;
    end else if (dn && m_st != 0 && m_st != 4) begin
      nph = 4;
    end else if (m_st == 3) begin
      nl = s;
    end else if (step) begin
      if (m_st == 1) begin
        nl = (m_lvl < MAXL) ? m_lvl + 1 : MAXL;
        if (nl == MAXL) nph = POST;
      end else if (m_st == 2) begin
        nl = m_lvl - 1;
        if (nl <= s) begin nl = s; nph = (s == 0) ? 0 : 3; end
      end else if (m_st == 4) begin
        nl = (m_lvl > 0) ? m_lvl - 1 : 0;
        if (nl == 0) nph = 0;
      end else if (m_st == 5) begin
        nph = 2;
      end
    end
    m_wait  = (up || step || nph != m_st) ? 0 : m_wait + 1;
    m_done  = (nph == 0) && (m_st != 0);
    m_st    = nph;
    m_lvl   = nl;
    m_gprev = gate;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lvl = 0; m_st = 0; m_wait = 0; m_done = 0; m_gprev = 0;
    end else begin
      model_clock();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Pin a DUT output and the model to the same hand-computed value.
  task automatic pin(input string nm, input int act, input int mdl, input int exp);
    chk(nm, act, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_level",   int'(level),   m_lvl);
      chk("cyc_state",   int'(state),   m_st);
      chk("cyc_running", int'(running), int'(m_st != 0));
      chk("cyc_done",    int'(done),    int'(m_done));
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int hold_cnt;
    rst_n = 1'b0; gate = 1'b0; retrig_zero = 1'b1;
    a_int = '0; d_int = '0; r_int = '0; sus_lvl = '0;
`ifdef ADSR_HOLD_EN
    hold_int = '0;
`endif
    #1 chk_en = 1;
    clks(3);
    pin("rst_level",   int'(level),   m_lvl,         0);
    pin("rst_state",   int'(state),   m_st,          0);
    pin("rst_running", int'(running), int'(m_st!=0), 0);
    pin("rst_done",    int'(done),    int'(m_done),  0);
    rst_n = 1'b1;
    clks(2);

    // Fast attack, decay to sustain 128, then live sustain follow.
    a_int = 8'd0; d_int = 8'd1; r_int = 8'd3; sus_lvl = 8'd128; retrig_zero = 1'b1;
    gate = 1'b1;
    clks(1);
    pin("atk_start_state", int'(state), m_st, 1);
    pin("atk_start_level", int'(level), m_lvl, 0);
    clks(255);
    pin("atk_peak_level", int'(level), m_lvl, 255);
    pin("atk_peak_state", int'(state), m_st, POST);
    clks(253 + HX);
    pin("dec_pre_level", int'(level), m_lvl, 129);
    pin("dec_pre_state", int'(state), m_st, 2);
    clks(1);
    pin("sus_level", int'(level), m_lvl, 128);
    pin("sus_state", int'(state), m_st, 3);
    sus_lvl = 8'd100;
    clks(1);
    pin("sus_follow", int'(level), m_lvl, 100);
    sus_lvl = 8'd128;
    clks(1);
    pin("sus_back", int'(level), m_lvl, 128);

    // Release from 128 with r_int=3: one step per 4 clocks.
    gate = 1'b0;
    clks(1);
    pin("rel_start_state", int'(state), m_st, 4);
    pin("rel_start_level", int'(level), m_lvl, 128);
    clks(511);
    pin("rel_last_level", int'(level), m_lvl, 1);
    clks(1);
    pin("rel_end_level", int'(level), m_lvl, 0);
    pin("rel_end_state", int'(state), m_st, 0);
    pin("rel_end_done",  int'(done),  int'(m_done), 1);
    pin("rel_end_run",   int'(running), int'(m_st!=0), 0);
    clks(1);
    pin("done_pulse_end", int'(done), int'(m_done), 0);

    // Retrigger during release at level 60.
    gate = 1'b1;
    clks(61);
    pin("rt_atk60", int'(level), m_lvl, 60);
    gate = 1'b0;
    clks(1);
    pin("rt_rel_state", int'(state), m_st, 4);
    pin("rt_rel_level", int'(level), m_lvl, 60);
    retrig_zero = 1'b0; gate = 1'b1;
    clks(1);
    pin("rt_keep_state", int'(state), m_st, 1);
    pin("rt_keep_level", int'(level), m_lvl, 60);
    clks(1);
    pin("rt_keep_step", int'(level), m_lvl, 61);
    gate = 1'b0;
    clks(1);
    retrig_zero = 1'b1; gate = 1'b1;
    clks(1);
    pin("rt_zero_state", int'(state), m_st, 1);
    pin("rt_zero_level", int'(level), m_lvl, 0);

    // Zero sustain: decay runs to 0, ends in IDLE with a single done, gate still high.
    d_int = 8'd0; sus_lvl = 8'd0;
    dones = 0;
    for (int i = 0; i < 700; i++) begin
      clks(1);
      if (done) dones++;
    end
    chk("sus0_done_count", dones, 1);
    pin("sus0_state", int'(state), m_st, 0);
    pin("sus0_level", int'(level), m_lvl, 0);

    // Asynchronous reset mid-attack at level 90.
    gate = 1'b0; sus_lvl = 8'd128;
    clks(1);
    gate = 1'b1;
    clks(91);
    pin("ar_pre_level", int'(level), m_lvl, 90);
    #1 rst_n = 1'b0;
    #1;
    pin("ar_level", int'(level), m_lvl, 0);
    pin("ar_state", int'(state), m_st, 0);
    pin("ar_run",   int'(running), int'(m_st!=0), 0);
    clks(3);
    pin("ar_held_level", int'(level), m_lvl, 0);
    rst_n = 1'b1;
    gate = 1'b0;
    clks(2);

`ifdef ADSR_HOLD_EN
    // Hold stage: 10 clocks at MAX with hold_int=9, then decay.
    hold_int = 8'd9; a_int = 8'd0; d_int = 8'd0; retrig_zero = 1'b1;
    gate = 1'b1;
    clks(256);
    pin("hold_enter_state", int'(state), m_st, 5);
    pin("hold_enter_level", int'(level), m_lvl, 255);
    clks(9);
    pin("hold_last_state", int'(state), m_st, 5);
    clks(1);
    pin("hold_exit_state", int'(state), m_st, 2);
    pin("hold_exit_level", int'(level), m_lvl, 255);
    clks(1);
    pin("hold_first_step", int'(level), m_lvl, 254);
    gate = 1'b0;
    clks(2);
`endif

    // Random run: long and short gate periods, live interval/sustain changes, rare resets.
    hold_cnt = 10;
    for (int c = 0; c < 20000; c++) begin
      clks(1);
      if (hold_cnt == 0) begin
        gate = ~gate;
        hold_cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(20, 1200);
      end else begin
        hold_cnt--;
      end
      if ($urandom_range(0, 99) == 0) retrig_zero = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) begin
        a_int = 8'($urandom_range(0, 2));
        d_int = 8'($urandom_range(0, 2));
        r_int = 8'($urandom_range(0, 3));
`ifdef ADSR_HOLD_EN
        hold_int = 8'($urandom_range(0, 12));
`endif
      end
      if ($urandom_range(0, 79) == 0) begin
        case ($urandom_range(0, 3))
          0: sus_lvl = 8'd0;
          1: sus_lvl = 8'd255;
          default: sus_lvl = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 2999) == 0) begin
        #1 rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
      end
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
